instr_fetch: RTL and testbench

Instruction fetch / sequencing unit for the 9-bit CSE141L core. It owns the program counter, addresses the instruction ROM and receives each 9-bit instruction back. It consumes the decoder's `branch_en` and the ALU negative flag to choose the next PC, and detects the `stp` opcode to halt the machine. It sits upstream of the control decoder: it supplies the instruction that the decoder consumes and acts on the decoder's branch decision.

---
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch / sequencing unit for the 9-bit core: owns the PC, follows
// taken bneg branches with zero bubbles and halts on the stp opcode.
module instr_fetch #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [8:0]      instruction,
    input  logic            branch_en,
    input  logic            neg_flag,
    input  logic            stall,
    output logic [PC_W-1:0] prog_ctr,
    output logic            running,
    output logic            done,
    output logic [15:0]     instr_count
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt, pc_seq, pc_br;
    logic [15:0]     cnt_nxt, cnt_inc;
    logic            is_stp;

    assign is_stp  = (instruction[8:6] == 3'b000);
    assign pc_seq  = prog_ctr + PC_W'(1);
    // Signed size cast sign-extends the 6-bit offset (or truncates for narrow PCs); wrap is modular.
    assign pc_br   = prog_ctr + PC_W'($signed(instruction[5:0]));
    assign cnt_inc = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            prog_ctr    <= START_PC;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            prog_ctr    <= pc_nxt;
            instr_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        cnt_nxt   = instr_count;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // A stalled cycle retires nothing; stp leaves the PC on its own address.
                if (!stall) begin
                    cnt_nxt = cnt_inc;
                    if (is_stp)
                        state_nxt = HALT;
                    else if (branch_en && neg_flag)
                        pc_nxt = pc_br;
                    else
                        pc_nxt = pc_seq;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        done    = (state == HALT);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (PC_W=10/START=0 and PC_W=4/START=15) fed
// from bench ROMs, checked every cycle against a behavioural model plus literals.
module tb_instr_fetch;

    logic        Clk, Reset, start, stall, neg_flag;
    logic [8:0]  instruction, instruction4;
    logic        branch_en, branch_en4;
    logic [9:0]  prog_ctr;
    logic [3:0]  prog_ctr4;
    logic        running, done, running4, done4;
    logic [15:0] instr_count, instr_count4;

    // ROM word = {branch_en, instruction}
    logic [9:0] rom  [1024];
    logic [9:0] rom4 [16];

    assign {branch_en, instruction}   = rom[prog_ctr];
    assign {branch_en4, instruction4} = rom4[prog_ctr4];

    instr_fetch #(.PC_W(10), .START_ADDR(0)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .instruction(instruction),
        .branch_en(branch_en), .neg_flag(neg_flag), .stall(stall),
        .prog_ctr(prog_ctr), .running(running), .done(done), .instr_count(instr_count)
    );

    instr_fetch #(.PC_W(4), .START_ADDR(15)) dut4 (
        .Clk(Clk), .Reset(Reset), .start(start), .instruction(instruction4),
        .branch_en(branch_en4), .neg_flag(neg_flag), .stall(stall),
        .prog_ctr(prog_ctr4), .running(running4), .done(done4), .instr_count(instr_count4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: st 0=idle 1=run 2=halt; pc and count kept as plain integers.
    typedef struct packed { int st; int pc; int cnt; } mst_t;

    function automatic mst_t mstep(mst_t s, bit rst, bit strt, bit stl,
                                   logic [9:0] word, bit neg, int pcw, int sa);
        mst_t n = s;
        int   m = 1 << pcw;
        int   off;
        if (rst) begin
            n.st = 0; n.pc = sa; n.cnt = 0;
        end else if (s.st != 1) begin
            if (strt) begin n.st = 1; n.pc = sa; n.cnt = 0; end
        end else if (!stl) begin
            n.cnt = (s.cnt >= 65535) ? 65535 : s.cnt + 1;
            if (word[8:6] == 3'b000) n.st = 2;
            else if (word[9] && neg) begin
                off = int'(word[5:0]);
                if (word[5]) off = off - 64;
                n.pc = (((s.pc + off) % m) + m) % m;
            end else n.pc = (s.pc + 1) % m;
        end
        return n;
    endfunction

    mst_t m  = '{st: 0, pc: 0,  cnt: 0};
    mst_t m4 = '{st: 0, pc: 15, cnt: 0};

    always @(posedge Clk) begin
        m  <= mstep(m,  Reset, start, stall, rom[m.pc],   neg_flag, 10, 0);
        m4 <= mstep(m4, Reset, start, stall, rom4[m4.pc], neg_flag, 4, 15);
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model pc",       int'(prog_ctr),     m.pc);
            chk("model running",  int'(running),      int'(m.st == 1));
            chk("model done",     int'(done),         int'(m.st == 2));
            chk("model count",    int'(instr_count),  m.cnt);
            chk("model4 pc",      int'(prog_ctr4),    m4.pc);
            chk("model4 running", int'(running4),     int'(m4.st == 1));
            chk("model4 done",    int'(done4),        int'(m4.st == 2));
            chk("model4 count",   int'(instr_count4), m4.cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic fill_add();
        for (int i = 0; i < 1024; i++) rom[i] = 10'h100;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; stall = 1'b0; neg_flag = 1'b1;
        fill_add();
        for (int i = 0; i < 16; i++) rom4[i] = 10'h100;
        rom4[0] = 10'h27F;                        // taken-capable bneg, offset -1
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("reset pc",      int'(prog_ctr), 0);
        chk("reset running", int'(running), 0);
        chk("reset done",    int'(done), 0);
        chk("reset count",   int'(instr_count), 0);
        chk("reset pc4",     int'(prog_ctr4), 15);

        // start on the same edge as Reset: Reset wins
        start = 1'b1;
        tick(1);
        chk("reset+start running", int'(running), 0);
        Reset = 1'b0; start = 1'b0;
        tick(1);
        chk("idle hold running", int'(running), 0);

        // add, addi, stp
        rom[0] = 10'h100; rom[1] = 10'h140; rom[2] = 10'h000;
        pulse_start();
        chk("t1 pc0", int'(prog_ctr), 0);
        chk("t1 running", int'(running), 1);
        chk("t1 pc4 start", int'(prog_ctr4), 15);
        tick(1);
        chk("t1 pc1", int'(prog_ctr), 1);
        chk("t1 pc4 wrap", int'(prog_ctr4), 0);
        tick(1);
        chk("t1 pc2", int'(prog_ctr), 2);
        chk("t1 pc4 back", int'(prog_ctr4), 15);
        tick(1);
        chk("t1 done", int'(done), 1);
        chk("t1 running off", int'(running), 0);
        chk("t1 stp pc", int'(prog_ctr), 2);
        chk("t1 count", int'(instr_count), 3);

        // bneg at 5, offset -3; restart from HALT
        fill_add();
        rom[5] = 10'h27D; rom[6] = 10'h000;
        pulse_start();
        chk("t2 restart done", int'(done), 0);
        chk("t2 restart pc", int'(prog_ctr), 0);
        chk("t2 restart count", int'(instr_count), 0);
        tick(6);
        chk("t2 taken pc", int'(prog_ctr), 2);
        tick(3);
        chk("t2 back at 5", int'(prog_ctr), 5);
        neg_flag = 1'b0;
        tick(1);
        chk("t2 not taken pc", int'(prog_ctr), 6);
        tick(1);
        chk("t2 halt", int'(done), 1);
        chk("t2 count", int'(instr_count), 11);
        neg_flag = 1'b1;

        // stall 3 cycles with stp presented
        fill_add();
        rom[3] = 10'h000;
        pulse_start();
        tick(3);
        chk("t3 at stp", int'(prog_ctr), 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t3 stall pc", int'(prog_ctr), 3);
            chk("t3 stall count", int'(instr_count), 3);
            chk("t3 stall done", int'(done), 0);
        end
        stall = 1'b0;
        tick(1);
        chk("t3 halt", int'(done), 1);
        chk("t3 count", int'(instr_count), 4);

        // Reset mid-run with stall high
        fill_add();
        pulse_start();
        tick(7);
        chk("t4 pc7", int'(prog_ctr), 7);
        chk("t4 count7", int'(instr_count), 7);
        Reset = 1'b1; stall = 1'b1;
        tick(1);
        chk("t4 reset pc", int'(prog_ctr), 0);
        chk("t4 reset running", int'(running), 0);
        chk("t4 reset done", int'(done), 0);
        chk("t4 reset count", int'(instr_count), 0);
        Reset = 1'b0; stall = 1'b0;
        pulse_start();
        chk("t4 rerun pc", int'(prog_ctr), 0);
        tick(1);
        chk("t4 rerun pc1", int'(prog_ctr), 1);

        // zero-offset taken branch until the counter saturates
        fill_add();
        rom[0] = 10'h240;
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        pulse_start();
        tick(65540);
        chk("t5 sat count", int'(instr_count), 65535);
        chk("t5 sat pc", int'(prog_ctr), 0);
        chk("t5 sat running", int'(running), 1);
        tick(3);
        chk("t5 sat hold", int'(instr_count), 65535);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
